// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle core:
// opcodes, FSM states and flag bit positions.
package cpu_mc_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SUBI = 5'b01001;
  localparam logic [4:0] OP_MOV  = 5'b01010;
  localparam logic [4:0] OP_LDI  = 5'b01011;
  localparam logic [4:0] OP_LD   = 5'b01100;
  localparam logic [4:0] OP_ST   = 5'b01101;
  localparam logic [4:0] OP_CMP  = 5'b01110;
  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_JZ   = 5'b10001;
  localparam logic [4:0] OP_JNZ  = 5'b10010;
  localparam logic [4:0] OP_JL   = 5'b10011;
  localparam logic [4:0] OP_JG   = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 2;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  function automatic logic op_legal(
    input logic [4:0] op
  );
    return (op <= OP_CMP)
      || (op >= OP_JMP && op <= OP_JG)
      || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: two async read ports, one
// sync write port, async clear to zero.
module cpu_mc_regfile
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle 8-bit-class core with req/ack
// instruction and data memory ports.
module cpu_mc_core
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2,
  parameter int PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  output logic imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [4+2*REG_ADDR_W+DATA_W:0] imem_rdata,
  input  logic imem_ack,
  output logic dmem_req,
  output logic dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic dmem_ack,
  output logic halted,
  output logic illegal,
  output logic [PC_W-1:0] pc_dbg
);

  localparam int INSTR_W = 5 + 2*REG_ADDR_W + DATA_W;
  localparam int RA = REG_ADDR_W;
  localparam int M  = DATA_W - 1;

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  logic [2:0]         flags;

  logic [4:0]        op;
  logic [RA-1:0]     rd;
  logic [RA-1:0]     rs;
  logic [DATA_W-1:0] imm;

  assign op  = ir[INSTR_W-1 -: 5];
  assign rd  = ir[DATA_W+2*RA-1 -: RA];
  assign rs  = ir[DATA_W+RA-1 -: RA];
  assign imm = ir[DATA_W-1:0];

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] bb;
  logic [DATA_W-1:0] res;
  logic [2:0]        fl_new;
  logic              ovf;
  logic              fl_we;
  logic              alu_wr;
  logic              taken;
  logic              is_jump;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  cpu_mc_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata),
    .raddr_a (rd),
    .rdata_a (a),
    .raddr_b (rs),
    .rdata_b (b)
  );

  always_comb begin
    bb      = b;
    res     = a;
    ovf     = 1'b0;
    fl_we   = 1'b0;
    alu_wr  = 1'b0;
    taken   = 1'b0;
    is_jump = 1'b0;
    unique case (op)
      OP_ADD, OP_ADDI: begin
        bb     = (op == OP_ADDI) ? imm : b;
        res    = a + bb;
        ovf    = (a[M] == bb[M]) && (res[M] != a[M]);
        fl_we  = 1'b1;
        alu_wr = 1'b1;
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        bb     = (op == OP_SUBI) ? imm : b;
        res    = a - bb;
        ovf    = (a[M] != bb[M]) && (res[M] != a[M]);
        fl_we  = 1'b1;
        alu_wr = (op != OP_CMP);
      end
      OP_AND: begin
        res    = a & b;
        fl_we  = 1'b1;
        alu_wr = 1'b1;
      end
      OP_OR: begin
        res    = a | b;
        fl_we  = 1'b1;
        alu_wr = 1'b1;
      end
      OP_XOR: begin
        res    = a ^ b;
        fl_we  = 1'b1;
        alu_wr = 1'b1;
      end
      OP_SHL: begin
        res    = {a[M-1:0], 1'b0};
        fl_we  = 1'b1;
        alu_wr = 1'b1;
      end
      OP_SHR: begin
        res    = {1'b0, a[M:1]};
        fl_we  = 1'b1;
        alu_wr = 1'b1;
      end
      OP_MOV: begin
        res    = b;
        alu_wr = 1'b1;
      end
      OP_LDI: begin
        res    = imm;
        alu_wr = 1'b1;
      end
      OP_JMP: begin
        is_jump = 1'b1;
        taken   = 1'b1;
      end
      OP_JZ: begin
        is_jump = 1'b1;
        taken   = flags[FLAG_Z];
      end
      OP_JNZ: begin
        is_jump = 1'b1;
        taken   = !flags[FLAG_Z];
      end
      OP_JL: begin
        is_jump = 1'b1;
        taken   = flags[FLAG_S] ^ flags[FLAG_O];
      end
      OP_JG: begin
        is_jump = 1'b1;
        taken   = !flags[FLAG_Z]
          && (flags[FLAG_S] == flags[FLAG_O]);
      end
      default: ;
    endcase
    fl_new         = '0;
    fl_new[FLAG_Z] = (res == '0);
    fl_new[FLAG_S] = res[M];
    fl_new[FLAG_O] = ovf;
  end

  // Loads write back from the data bus in MEM
  assign rf_we = ((state == S_EXEC) && alu_wr)
    || ((state == S_MEM) && dmem_req
        && dmem_ack && !dmem_we);
  assign rf_wdata = (state == S_MEM) ? dmem_rdata : res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      ir         <= '0;
      flags      <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      unique case (state)
        S_BOOT: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            illegal  <= !op_legal(
              imem_rdata[INSTR_W-1 -: 5]);
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (fl_we)
            flags <= fl_new;
          if (op == OP_LD || op == OP_ST) begin
            dmem_req   <= 1'b1;
            dmem_we    <= (op == OP_ST);
            dmem_addr  <= b;
            dmem_wdata <= a;
            state      <= S_MEM;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc <= (is_jump && taken)
              ? imm[PC_W-1:0]
              : pc + PC_W'(1);
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_req && dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            pc         <= pc + PC_W'(1);
            imem_req   <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_BOOT;
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_dbg    = pc;

endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed bench for cpu_mc_core with wait-state
// instruction and data memory models.
module tb_cpu_mc_core;

  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] ADD  = 5'b00001;
  localparam logic [4:0] SUB  = 5'b00010;
  localparam logic [4:0] AND_ = 5'b00011;
  localparam logic [4:0] OR_  = 5'b00100;
  localparam logic [4:0] XOR_ = 5'b00101;
  localparam logic [4:0] SHL  = 5'b00110;
  localparam logic [4:0] SHR  = 5'b00111;
  localparam logic [4:0] ADDI = 5'b01000;
  localparam logic [4:0] SUBI = 5'b01001;
  localparam logic [4:0] MOV  = 5'b01010;
  localparam logic [4:0] LDI  = 5'b01011;
  localparam logic [4:0] LD   = 5'b01100;
  localparam logic [4:0] ST   = 5'b01101;
  localparam logic [4:0] CMP  = 5'b01110;
  localparam logic [4:0] JMP  = 5'b10000;
  localparam logic [4:0] JZ   = 5'b10001;
  localparam logic [4:0] JL   = 5'b10011;
  localparam logic [4:0] JG   = 5'b10100;
  localparam logic [4:0] HALT = 5'b11111;
  localparam logic [4:0] BAD  = 5'b11000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [16:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;
  logic        halted;
  logic        illegal;
  logic [7:0]  pc_dbg;

  cpu_mc_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .halted     (halted),
    .illegal    (illegal),
    .pc_dbg     (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] imem [256];
  logic [7:0]  dmem [256];
  int iw;
  int dw;
  int icnt;
  int dcnt;
  int cyc;
  int ill_cnt;
  logic [7:0] fq [$];
  int         ft [$];

  int checks;
  int errors;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end
  end

  assign imem_ack   = imem_req && (icnt == iw);
  assign dmem_ack   = dmem_req && (dcnt == dw);
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
      fq.delete();
      ft.delete();
      ill_cnt = 0;
    end else begin
      if (imem_req && imem_ack) begin
        fq.push_back(imem_addr);
        ft.push_back(cyc);
      end
      if (dmem_req && dmem_ack && dmem_we)
        dmem[dmem_addr] = dmem_wdata;
      if (illegal) ill_cnt++;
    end
  end

  function automatic logic [16:0] ins(
    input logic [4:0] op,
    input logic [1:0] rd,
    input logic [1:0] rs,
    input logic [7:0] imm
  );
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
        nm, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 17'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_halt(input string nm);
    int n;
    n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_halt"}, 32'(halted), 32'd1);
  endtask

  task automatic chk_fetch(
    input string nm,
    input int    idx,
    input int    exp
  );
    int act;
    act = (idx < fq.size()) ? int'(fq[idx]) : -1;
    chk(nm, act, exp);
  endtask

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [7:0] res;
    logic [2:0] fl;
  } vec_t;

  vec_t vt [15];

  initial begin
    int n;
    int exp_f [6];
    logic [7:0] sa;
    logic [7:0] sd;
    checks = 0;
    errors = 0;
    iw = 0;
    dw = 0;

    // fl is {OF, SF, ZF}
    vt[0]  = '{ADD,  8'h7F, 8'h01, 8'h00, 8'h80, 3'b110};
    vt[1]  = '{ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 3'b001};
    vt[2]  = '{SUB,  8'h80, 8'h01, 8'h00, 8'h7F, 3'b100};
    vt[3]  = '{SUB,  8'h05, 8'h05, 8'h00, 8'h00, 3'b001};
    vt[4]  = '{AND_, 8'hF0, 8'h3C, 8'h00, 8'h30, 3'b000};
    vt[5]  = '{OR_,  8'hF0, 8'h0F, 8'h00, 8'hFF, 3'b010};
    vt[6]  = '{XOR_, 8'hAA, 8'hAA, 8'h00, 8'h00, 3'b001};
    vt[7]  = '{SHL,  8'h81, 8'h00, 8'h00, 8'h02, 3'b000};
    vt[8]  = '{SHR,  8'h81, 8'h00, 8'h00, 8'h40, 3'b000};
    vt[9]  = '{ADDI, 8'h10, 8'h00, 8'h05, 8'h15, 3'b000};
    vt[10] = '{SUBI, 8'h00, 8'h00, 8'h01, 8'hFF, 3'b010};
    vt[11] = '{MOV,  8'h12, 8'h34, 8'h00, 8'h34, 3'b000};
    vt[12] = '{CMP,  8'h03, 8'h05, 8'h00, 8'h03, 3'b010};
    vt[13] = '{CMP,  8'h80, 8'h01, 8'h00, 8'h80, 3'b100};
    vt[14] = '{LDI,  8'h00, 8'h00, 8'h5A, 8'h5A, 3'b000};

    // reset and boot
    clear_imem();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_reqs",
      {imem_req, dmem_req, dmem_we, halted, illegal},
      32'd0);
    chk("rst_daddr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_pc", pc_dbg, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("boot_noreq", imem_req, 32'd0);
    @(negedge clk);
    chk("fetch_req", imem_req, 32'd1);
    chk("fetch_addr", imem_addr, 32'd0);
    chk("fetch_other",
      {dmem_req, dmem_we, halted, illegal,
       dmem_addr, dmem_wdata},
      32'd0);

    // ALU vectors
    foreach (vt[k]) begin
      clear_imem();
      imem[0] = ins(LDI, 2'd0, 2'd0, vt[k].a);
      imem[1] = ins(LDI, 2'd1, 2'd0, vt[k].b);
      imem[2] = ins(vt[k].op, 2'd0, 2'd1, vt[k].imm);
      imem[3] = ins(LDI, 2'd2, 2'd0, 8'h80);
      imem[4] = ins(ST, 2'd0, 2'd2, 8'h00);
      imem[5] = ins(HALT, 2'd0, 2'd0, 8'h00);
      do_reset();
      run_halt($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_res", k),
        dmem[8'h80], vt[k].res);
      chk($sformatf("vec%0d_flags", k),
        dut.flags, vt[k].fl);
    end

    // overflow then signed branches
    clear_imem();
    imem[0] = ins(LDI, 2'd0, 2'd0, 8'h7F);
    imem[1] = ins(ADDI, 2'd0, 2'd0, 8'h01);
    imem[2] = ins(JL, 2'd0, 2'd0, 8'h20);
    imem[3] = ins(CMP, 2'd1, 2'd1, 8'h00);
    imem[4] = ins(JG, 2'd0, 2'd0, 8'h20);
    imem[5] = ins(HALT, 2'd0, 2'd0, 8'h00);
    imem[8'h20] = ins(HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    run_halt("jmp");
    exp_f = '{0, 1, 2, 3, 4, 5};
    foreach (exp_f[i])
      chk($sformatf("jmp_fetch%0d", i),
        (i < fq.size()) ? int'(fq[i]) : -1,
        exp_f[i]);
    chk("cpi_alu",
      (ft.size() > 1) ? ft[1] - ft[0] : -1, 2);
    chk("jmp_pc", pc_dbg, 32'd5);

    // load/store with wait states
    iw = 2;
    dw = 3;
    clear_imem();
    imem[0] = ins(LDI, 2'd1, 2'd0, 8'h10);
    imem[1] = ins(LDI, 2'd2, 2'd0, 8'hA5);
    imem[2] = ins(ST, 2'd2, 2'd1, 8'h00);
    imem[3] = ins(LD, 2'd3, 2'd1, 8'h00);
    imem[4] = ins(ST, 2'd3, 2'd0, 8'h00);
    imem[5] = ins(HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    n = 0;
    while (!dmem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("st_req", dmem_req, 32'd1);
    chk("st_addr", dmem_addr, 32'h10);
    chk("st_wdata", dmem_wdata, 32'hA5);
    chk("st_we", dmem_we, 32'd1);
    sa = dmem_addr;
    sd = dmem_wdata;
    n = 0;
    while (!dmem_ack && n < 10) begin
      @(negedge clk);
      n++;
      chk("st_hold",
        {dmem_req, dmem_we, dmem_addr, dmem_wdata},
        {1'b1, 1'b1, sa, sd});
    end
    run_halt("ldst");
    chk("st_mem", dmem[8'h10], 32'hA5);
    chk("ld_val", dmem[8'h00], 32'hA5);
    chk("cpi_st",
      (ft.size() > 3) ? ft[3] - ft[2] : -1,
      3 + iw + dw);
    chk("cpi_ld",
      (ft.size() > 4) ? ft[4] - ft[3] : -1,
      3 + iw + dw);
    iw = 0;
    dw = 0;

    // PC wrap and taken JZ
    clear_imem();
    imem[0]     = ins(JMP, 2'd0, 2'd0, 8'hFF);
    imem[8'hFF] = ins(NOP, 2'd0, 2'd0, 8'h00);
    imem[8'h40] = ins(HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    n = 0;
    while (!(imem_req && imem_addr == 8'hFF) && n < 50) begin
      @(negedge clk);
      n++;
    end
    imem[0] = ins(SUB, 2'd0, 2'd0, 8'h00);
    imem[1] = ins(JZ, 2'd0, 2'd0, 8'h40);
    run_halt("wrap");
    exp_f = '{0, 8'hFF, 0, 1, 8'h40, -1};
    for (int i = 0; i < 5; i++)
      chk_fetch($sformatf("wrap_fetch%0d", i),
        i, exp_f[i]);

    // illegal opcode then HALT
    clear_imem();
    imem[0] = ins(LDI, 2'd1, 2'd0, 8'h33);
    imem[1] = ins(BAD, 2'd1, 2'd0, 8'hFF);
    imem[2] = ins(HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    run_halt("ill");
    chk("ill_pulses", ill_cnt, 32'd1);
    chk_fetch("ill_next", 2, 2);
    chk("halt_pc", pc_dbg, 32'd2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || !halted) n++;
    end
    chk("halt_quiet", n, 32'd0);
    chk("halt_r1", dut.u_rf.regs[1], 32'h33);
    chk("halt_ill_low", illegal, 32'd0);

    // reset during a stalled load
    dw = 1000;
    clear_imem();
    imem[0] = ins(LDI, 2'd1, 2'd0, 8'h55);
    imem[1] = ins(LDI, 2'd2, 2'd0, 8'h20);
    imem[2] = ins(LD, 2'd3, 2'd2, 8'h00);
    do_reset();
    n = 0;
    while (!dmem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("mid_req", dmem_req, 32'd1);
    chk("mid_r1", dut.u_rf.regs[1], 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_drop", {dmem_req, imem_req}, 32'd0);
    chk("mid_regs_r1", dut.u_rf.regs[1], 32'h00);
    chk("mid_regs_r2", dut.u_rf.regs[2], 32'h00);
    dw = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_boot", imem_req, 32'd0);
    @(negedge clk);
    chk("mid_refetch",
      {imem_req, imem_addr}, {1'b1, 8'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
